// File: rtl/ldpc_pkg.sv
// Shared LDPC datapath definitions.
// Holds the default widths of the layered decoder, the matching
// symmetric saturation limits and the clamp function used by both the
// variable-node subtract (issue) and add (retire) paths.
package ldpc_pkg;

  localparam int DATA_W   = 8;   // message width (q, r)
  localparam int LLR_W    = 10;  // posterior LLR width
  localparam int DEG      = 8;   // check-node degree (lanes per row)
  localparam int DATA_MAX = 2**(DATA_W-1) - 1;
  localparam int LLR_MAX  = 2**(LLR_W-1) - 1;

  // Symmetric clamp to [-max, +max]; the most negative code is never
  // produced so a later negation cannot overflow.
  function automatic int sat_sym(input int v, input int max);
    if (v > max)
      return max;
    else if (v < -max)
      return -max;
    else
      return v;
  endfunction

endpackage

// File: rtl/vnu_dly.sv
// vnu_dly: valid/tag/data shift register of fixed depth, used to carry an
// issued row alongside the CNU pipeline until its r vector is valid.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (valids only)
//   flush           synchronous clear of every valid bit
//   vld, tag, data  stage-0 input
//   tap_vld         valid bit of every stage (index 0 = youngest)
//   tap_tag         tag of every stage, stage k at [k*TAG_W +: TAG_W]
//   last_data       data of the oldest stage
module vnu_dly
  import ldpc_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int TAG_W = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   vld,
  input  logic [TAG_W-1:0]       tag,
  input  logic [WIDTH-1:0]       data,
  output logic [DEPTH-1:0]       tap_vld,
  output logic [DEPTH*TAG_W-1:0] tap_tag,
  output logic [WIDTH-1:0]       last_data
);

  logic [TAG_W-1:0] tag_p  [DEPTH];
  logic [WIDTH-1:0] data_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_vld <= '0;
    end else if (flush) begin
      tap_vld <= '0;
    end else begin
      tap_vld[0] <= vld;
      for (int k = 1; k < DEPTH; k++)
        tap_vld[k] <= tap_vld[k-1];
    end
  end

  // Tags and data are qualified by tap_vld, so they need no reset.
  always_ff @(posedge clk) begin
    tag_p[0]  <= tag;
    data_p[0] <= data;
    for (int k = 1; k < DEPTH; k++) begin
      tag_p[k]  <= tag_p[k-1];
      data_p[k] <= data_p[k-1];
    end
  end

  always_comb begin
    tap_tag = '0;
    for (int k = 0; k < DEPTH; k++)
      tap_tag[k*TAG_W +: TAG_W] = tag_p[k];
  end

  assign last_data = data_p[DEPTH-1];

endmodule

// File: rtl/vnu_layer.sv
// vnu_layer: layered-decoding variable-node stage wrapped around a CNU.
// Accepts a row of D posterior LLRs, subtracts the stored check-to-variable
// messages of that row to form q, and when r returns CNU_LAT cycles later
// adds it back, stores r as the row's new messages and emits updated LLRs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   init                     synchronous codeword start: clears store, flushes
//   in_valid/in_ready        row handshake (in_ready combinational on in_row)
//   in_row, in_llr           row index and D posterior LLRs
//   q, q_valid               variable-to-check messages towards the CNU
//   r                        check-to-variable messages from the CNU
//   out_valid/out_row/out_llr  one-cycle updated LLR row
module vnu_layer
  import ldpc_pkg::*;
#(
  parameter int data_w  = DATA_W,
  parameter int llr_w   = LLR_W,
  parameter int D       = DEG,
  parameter int ROWS    = 16,
  parameter int row_w   = 4,
  parameter int CNU_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [row_w-1:0]     in_row,
  input  logic [llr_w*D-1:0]   in_llr,
  output logic [data_w*D-1:0]  q,
  output logic                 q_valid,
  input  logic [data_w*D-1:0]  r,
  output logic                 out_valid,
  output logic [row_w-1:0]     out_row,
  output logic [llr_w*D-1:0]   out_llr
);

  localparam int DMAX = 2**(data_w-1) - 1;
  localparam int LMAX = 2**(llr_w-1) - 1;
  localparam int QW   = data_w*D;

  logic signed [data_w-1:0] store [ROWS][D];

  logic [row_w-1:0]         q_row;
  logic [CNU_LAT-1:0]       tap_vld;
  logic [CNU_LAT*row_w-1:0] tap_row;
  logic [QW-1:0]            last_q;
  logic [row_w-1:0]         last_row;
  logic                     hit;
  logic                     accept;
  logic                     retire;
  logic [QW-1:0]            q_nxt;
  logic [llr_w*D-1:0]       llr_nxt;

  // A row may not issue while any earlier copy of it is still between the
  // q register and the retire stage, otherwise it would read r_old before
  // the pending write-back lands.
  always_comb begin
    hit = q_valid && (q_row == in_row);
    for (int k = 0; k < CNU_LAT; k++)
      if (tap_vld[k] && (tap_row[k*row_w +: row_w] == in_row))
        hit = 1'b1;
  end

  assign in_ready = !init && !hit;
  assign accept   = in_valid && in_ready;

  always_comb begin
    int diff;
    diff  = 0;
    q_nxt = '0;
    for (int i = 0; i < D; i++) begin
      diff = sat_sym(int'($signed(in_llr[i*llr_w +: llr_w])) - int'(store[in_row][i]), DMAX);
      q_nxt[i*data_w +: data_w] = diff[data_w-1:0];
    end
  end

  // ---- issue stage: q register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q       <= '0;
      q_row   <= '0;
    end else begin
      q_valid <= accept;
      if (accept) begin
        q     <= q_nxt;
        q_row <= in_row;
      end
    end
  end

  // ---- delay stages aligned with the CNU pipeline ----
  vnu_dly #(
    .DEPTH (CNU_LAT),
    .TAG_W (row_w),
    .WIDTH (QW)
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .flush     (init),
    .vld       (q_valid),
    .tag       (q_row),
    .data      (q),
    .tap_vld   (tap_vld),
    .tap_tag   (tap_row),
    .last_data (last_q)
  );

  assign last_row = tap_row[(CNU_LAT-1)*row_w +: row_w];
  assign retire   = tap_vld[CNU_LAT-1] && !init;

  always_comb begin
    int sum;
    sum     = 0;
    llr_nxt = '0;
    for (int i = 0; i < D; i++) begin
      sum = sat_sym(int'($signed(last_q[i*data_w +: data_w])) + int'($signed(r[i*data_w +: data_w])), LMAX);
      llr_nxt[i*llr_w +: llr_w] = sum[llr_w-1:0];
    end
  end

  // ---- retire stage: output register and message write-back ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_llr   <= '0;
    end else begin
      out_valid <= retire;
      if (retire) begin
        out_row <= last_row;
        out_llr <= llr_nxt;
      end
    end
  end

  // init clear wins over a retire write landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int rr = 0; rr < ROWS; rr++)
        for (int i = 0; i < D; i++)
          store[rr][i] <= '0;
    end else if (init) begin
      for (int rr = 0; rr < ROWS; rr++)
        for (int i = 0; i < D; i++)
          store[rr][i] <= '0;
    end else if (retire) begin
      for (int i = 0; i < D; i++)
        store[last_row][i] <= $signed(r[i*data_w +: data_w]);
    end
  end

endmodule

// File: tb/tb_vnu_layer.sv
module tb_vnu_layer;

  localparam int DG  = 8;
  localparam int NR  = 16;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_row = '0;
  logic [79:0] in_llr = '0;
  logic [63:0] q;
  logic        q_valid;
  logic [63:0] r;
  logic        out_valid;
  logic [3:0]  out_row;
  logic [79:0] out_llr;

  // second instance with llr_w = data_w = 8 for the LLR clamp case
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [63:0] in_llr8 = '0;
  logic [63:0] q8;
  logic        q_valid8;
  logic [63:0] r8;
  logic        out_valid8;
  logic [3:0]  out_row8;
  logic [63:0] out_llr8;

  vnu_layer dut (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_llr(in_llr), .q(q), .q_valid(q_valid), .r(r),
    .out_valid(out_valid), .out_row(out_row), .out_llr(out_llr)
  );

  vnu_layer #(.llr_w(8)) dut8 (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_row(4'd0), .in_llr(in_llr8), .q(q8), .q_valid(q_valid8), .r(r8),
    .out_valid(out_valid8), .out_row(out_row8), .out_llr(out_llr8)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- CNU stand-in: r = f(q), CNU_LAT cycles later ----------------
  bit rmode  = 1'b0;   // 0: constant rconst on every lane, 1: lane function of q
  int rconst = 0;

  function automatic int rfun(input int qi);
    logic signed [7:0] t;
    if (rmode) begin
      t = 8'(qi*5 + 13);
      return int'(t);
    end
    return rconst;
  endfunction

  function automatic logic [63:0] cnu_vec(input logic [63:0] qv);
    logic [63:0] v;
    for (int i = 0; i < DG; i++)
      v[i*8 +: 8] = 8'(rfun(int'($signed(qv[i*8 +: 8]))));
    return v;
  endfunction

  logic [63:0] cpipe [LAT];
  always @(posedge clk) begin
    for (int k = LAT-1; k > 0; k--) cpipe[k] <= cpipe[k-1];
    cpipe[0] <= cnu_vec(q);
  end
  assign r  = cpipe[LAT-1];
  assign r8 = {8{8'sd127}};

  // ---------------- reference model and scoreboard ----------------
  int st [NR][DG];

  function automatic int clamp(input int v, input int m);
    return (v > m) ? m : ((v < -m) ? -m : v);
  endfunction

  task automatic clear_store();
    for (int a = 0; a < NR; a++)
      for (int i = 0; i < DG; i++)
        st[a][i] = 0;
  endtask

  typedef struct {
    logic [3:0]  row;
    logic [79:0] llr;
    int          cyc;
  } oexp_t;

  oexp_t       oq [$];
  logic [63:0] qq [$];

  task automatic push(input int row, input int l[DG]);
    logic [63:0] qe;
    logic [79:0] le;
    oexp_t       e;
    int qi, ri, li;
    for (int i = 0; i < DG; i++) begin
      qi = clamp(l[i] - st[row][i], 127);
      ri = rfun(qi);
      li = clamp(qi + ri, 511);
      st[row][i] = ri;
      qe[i*8 +: 8]   = 8'(qi);
      le[i*10 +: 10] = 10'(li);
    end
    qq.push_back(qe);
    e.row = 4'(row);
    e.llr = le;
    e.cyc = cyc + 2 + LAT;
    oq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (q_valid) begin
        if (qq.size() == 0) check("q_unexpected", 1, 0);
        else check("q", q, qq.pop_front());
      end
      if (out_valid) begin
        if (oq.size() == 0) check("out_unexpected", 1, 0);
        else begin
          check("out_row", out_row, oq[0].row);
          check("out_llr", out_llr, oq[0].llr);
          check("out_latency", cyc, oq[0].cyc);
          void'(oq.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int row, input int l[DG], output bit acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_row   = 4'(row);
    for (int i = 0; i < DG; i++) in_llr[i*10 +: 10] = 10'(l[i]);
    #1;
    acc = in_ready;
    if (acc) push(row, l);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic fill(output int l[DG], input int v);
    for (int i = 0; i < DG; i++) l[i] = v;
  endtask

  initial begin
    int  L[DG];
    bit  acc;
    int  k;
    clear_store();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_q_valid", q_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_out_llr", out_llr, 0);
    check("rst_out_row", out_row, 0);
    rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // first iteration: r_old = 0, r = 0
    rmode = 0; rconst = 0;
    L = '{20, -30, 40, 5, 60, -70, 80, 90};
    send(0, L, acc); check("it1_acc", acc, 1);
    drain();
    send(0, L, acc); check("it1_reissue_acc", acc, 1);
    drain();

    // second pass on row 3: store 10, then q = 40, r = -12, out = 28
    fill(L, 50); rconst = 10;
    send(3, L, acc); check("p2_seed_acc", acc, 1);
    drain();
    rconst = -12;
    send(3, L, acc); check("p2_acc", acc, 1);
    drain();
    fill(L, 0); rconst = 0;
    send(3, L, acc); check("p2_readback_acc", acc, 1);
    drain();

    // q clamp: L = -511 against r_old = +100
    fill(L, 0); rconst = 100;
    send(7, L, acc); check("sat_seed_acc", acc, 1);
    drain();
    fill(L, -511); rconst = 0;
    send(7, L, acc); check("sat_acc", acc, 1);
    drain();

    // LLR clamp at llr_w = 8: q = 127, r = 127 -> +127
    @(negedge clk);
    in_valid8 = 1'b1;
    in_llr8   = {8{8'h7f}};
    #1 check("s8_ready", in_ready8, 1);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    @(negedge clk);
    check("s8_q_valid", q_valid8, 1);
    check("s8_q", q8, {8{8'h7f}});
    repeat (LAT + 1) @(negedge clk);
    check("s8_out_valid", out_valid8, 1);
    check("s8_out_llr", out_llr8, {8{8'h7f}});
    check("s8_out_row", out_row8, 0);

    // same-row hazard on row 5
    rmode = 1;
    L = '{3, -9, 27, -81, 100, -200, 300, -400};
    send(5, L, acc); check("hz_first_acc", acc, 1);
    for (int j = 1; j <= LAT + 2; j++) begin
      send(5, L, acc);
      check("hz_ready", acc, (j == LAT + 2));
    end
    drain();
    send(5, L, acc); check("hz_again_acc", acc, 1);
    send(6, L, acc); check("hz_other_row", acc, 1);
    drain();

    // random back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DG; i++) L[i] = int'($urandom_range(0, 1022)) - 511;
      send(int'($urandom_range(0, NR - 1)), L, acc);
    end
    drain();

    // init while rows 1, 2, 3 are in flight
    rmode = 0; rconst = 25;
    fill(L, 9);
    send(1, L, acc); check("init_r1_acc", acc, 1);
    send(2, L, acc); check("init_r2_acc", acc, 1);
    send(3, L, acc); check("init_r3_acc", acc, 1);
    @(negedge clk);
    init     = 1'b1;
    in_valid = 1'b1;
    in_row   = 4'd9;
    #1 check("init_in_ready", in_ready, 0);
    oq.delete();
    clear_store();
    @(posedge clk);
    #1 init = 1'b0;
    in_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    rconst = 0;
    for (int a = 0; a < NR; a++) begin
      for (int i = 0; i < DG; i++) L[i] = a*8 + i - 60;
      send(a, L, acc); check("init_clear_acc", acc, 1);
    end
    drain();

    // asynchronous reset while out_valid is high
    fill(L, 33);
    send(2, L, acc); check("ar_acc", acc, 1);
    k = 0;
    while (k < 20 && !out_valid) begin
      @(negedge clk);
      k++;
    end
    check("ar_out_seen", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_q_valid", q_valid, 0);
    check("ar_q", q, 0);
    check("ar_out_llr", out_llr, 0);
    check("ar_out_row", out_row, 0);
    qq.delete();
    oq.delete();
    clear_store();
    #1 rst = 1'b0;
    #1 check("ar_in_ready", in_ready, 1);
    fill(L, 7);
    send(4, L, acc); check("ar_post_acc", acc, 1);
    drain();

    check("q_left", qq.size(), 0);
    check("out_left", oq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
